// File: rtl/regfile_write_arbiter_if.sv
// Purpose: bundles the requester-side and register-file-side signals of the write arbiter.
// Latency: none, wires only.
// Backpressure: a requester holds req/addr/data until it sees its ack pulse.
// Ports: zero, req[2:0], addr0..2, data0..2 (requester -> arbiter);
//        ack[2:0], rf_write, rf_inaddr, rf_in, ready (arbiter -> requesters / register file).
interface regfile_write_arbiter_if #(
  parameter int DW = 16,
  parameter int AW = 3
);
  logic          zero;
  logic [2:0]    req;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [AW-1:0] addr2;
  logic [DW-1:0] data0;
  logic [DW-1:0] data1;
  logic [DW-1:0] data2;
  logic [2:0]    ack;
  logic          rf_write;
  logic [AW-1:0] rf_inaddr;
  logic [DW-1:0] rf_in;
  logic          ready;

  // Requester / register-file side.
  modport master (
    output zero, req, addr0, addr1, addr2, data0, data1, data2,
    input  ack, rf_write, rf_inaddr, rf_in, ready
  );

  // Arbiter side.
  modport slave (
    input  zero, req, addr0, addr1, addr2, data0, data1, data2,
    output ack, rf_write, rf_inaddr, rf_in, ready
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Purpose: round-robin arbiter of three register-file write requesters, with a zero-fill INIT sweep.
// Latency: 1 cycle from req to registered ack/rf_write; INIT sweep takes 2**AW cycles.
// Backpressure: requests are held (not dropped) during INIT and while another requester wins.
// Ports: clk, clear_n (async active-low) plain; bus.slave carries zero, req, addr0..2, data0..2 in
//        and ack, rf_write, rf_inaddr, rf_in, ready out (all outputs registered).
module regfile_write_arbiter #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic                   clk,
  input  logic                   clear_n,
  regfile_write_arbiter_if.slave bus
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_cnt,   w_cnt_nxt;
  logic [1:0]    r_ptr,   w_ptr_nxt;
  logic [2:0]    r_ack,   w_ack_nxt;
  logic          r_wr,    w_wr_nxt;
  logic [AW-1:0] r_addr,  w_addr_nxt;
  logic [DW-1:0] r_data,  w_data_nxt;
  logic          r_ready, w_ready_nxt;

  logic [2:0]    w_elig;
  logic [1:0]    w_idx1;
  logic [1:0]    w_idx2;
  logic [1:0]    w_win;
  logic          w_win_vld;

  // A requester whose ack is currently high is ignored for one cycle, which
  // gives the requester time to drop req and prevents back-to-back grants.
  assign w_elig = bus.req & ~r_ack;

  // Search order ptr, ptr+1, ptr+2 (mod 3); ptr only ever holds 0..2.
  assign w_idx1 = (r_ptr == 2'd2) ? 2'd0 : r_ptr + 2'd1;
  assign w_idx2 = (r_ptr == 2'd0) ? 2'd2 : r_ptr - 2'd1;

  always_comb begin
    w_win_vld = 1'b1;
    w_win     = r_ptr;
    if (w_elig[r_ptr]) begin
      w_win = r_ptr;
    end else if (w_elig[w_idx1]) begin
      w_win = w_idx1;
    end else if (w_elig[w_idx2]) begin
      w_win = w_idx2;
    end else begin
      w_win_vld = 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_ack_nxt   = 3'b000;
    w_wr_nxt    = 1'b0;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_ready_nxt = 1'b0;

    case (r_state)
      ST_INIT: begin
        // Sweep every address writing zero; cnt wraps back to 0 after the last one.
        w_wr_nxt   = 1'b1;
        w_addr_nxt = r_cnt;
        w_data_nxt = '0;
        w_cnt_nxt  = r_cnt + 1'b1;
        if (r_cnt == '1) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.zero) begin
          w_state_nxt = ST_INIT;
          w_cnt_nxt   = '0;
        end else begin
          // ready lags the state by one cycle so it rises after the last INIT write.
          w_ready_nxt = 1'b1;
          if (w_win_vld) begin
            w_ack_nxt = 3'b001 << w_win;
            w_wr_nxt  = 1'b1;
            w_ptr_nxt = (w_win == 2'd2) ? 2'd0 : w_win + 2'd1;
            case (w_win)
              2'd0: begin
                w_addr_nxt = bus.addr0;
                w_data_nxt = bus.data0;
              end
              2'd1: begin
                w_addr_nxt = bus.addr1;
                w_data_nxt = bus.data1;
              end
              default: begin
                w_addr_nxt = bus.addr2;
                w_data_nxt = bus.data2;
              end
            endcase
          end
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
      r_ptr   <= 2'd0;
      r_ack   <= 3'b000;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_ack   <= w_ack_nxt;
      r_wr    <= w_wr_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  assign bus.ack       = r_ack;
  assign bus.rf_write  = r_wr;
  assign bus.rf_inaddr = r_addr;
  assign bus.rf_in     = r_data;
  assign bus.ready     = r_ready;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Purpose: directed, table-driven check of the register-file write arbiter.
// Latency: outputs sampled 1 ns after each rising edge.
// Backpressure: requesters follow the hold-until-ack protocol in the stimulus.
module tb_regfile_write_arbiter;

  logic clk;
  logic clear_n;

  int n_cmp;
  int n_err;

  regfile_write_arbiter_if #(.DW(16), .AW(3)) bus ();

  regfile_write_arbiter #(.DW(16), .AW(3)) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        zero;
    logic [2:0]  req;
    logic [2:0]  exp_ack;
    logic        exp_wr;
    logic [2:0]  exp_addr;
    logic [15:0] exp_data;
    logic        exp_ready;
  } vec_t;

  vec_t vt [20];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] e_ack, input logic e_wr,
                       input logic [2:0] e_addr, input logic [15:0] e_data, input logic e_rdy);
    logic [23:0] act;
    logic [23:0] exp;
    act = {bus.ack, bus.rf_write, bus.rf_inaddr, bus.rf_in, bus.ready};
    exp = {e_ack, e_wr, e_addr, e_data, e_rdy};
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got ack=%b wr=%b addr=%0d data=%h ready=%b, want ack=%b wr=%b addr=%0d data=%h ready=%b",
               name, bus.ack, bus.rf_write, bus.rf_inaddr, bus.rf_in, bus.ready,
               e_ack, e_wr, e_addr, e_data, e_rdy);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clear_n   = 1'b1;
    bus.zero  = 1'b0;
    bus.req   = 3'b000;
    bus.addr0 = 3'd1;
    bus.addr1 = 3'd2;
    bus.addr2 = 3'd3;
    bus.data0 = 16'h0011;
    bus.data1 = 16'h0022;
    bus.data2 = 16'h0033;

    //           zero  req     ack     wr    addr  data      ready
    vt[0]  = '{1'b0, 3'b111, 3'b001, 1'b1, 3'd1, 16'h0011, 1'b1};
    vt[1]  = '{1'b0, 3'b111, 3'b010, 1'b1, 3'd2, 16'h0022, 1'b1};
    vt[2]  = '{1'b0, 3'b111, 3'b100, 1'b1, 3'd3, 16'h0033, 1'b1};
    vt[3]  = '{1'b0, 3'b111, 3'b001, 1'b1, 3'd1, 16'h0011, 1'b1};
    vt[4]  = '{1'b0, 3'b111, 3'b010, 1'b1, 3'd2, 16'h0022, 1'b1};
    vt[5]  = '{1'b0, 3'b111, 3'b100, 1'b1, 3'd3, 16'h0033, 1'b1};
    // Single persistent requester: granted every other cycle.
    vt[6]  = '{1'b0, 3'b010, 3'b010, 1'b1, 3'd2, 16'h0022, 1'b1};
    vt[7]  = '{1'b0, 3'b010, 3'b000, 1'b0, 3'd2, 16'h0022, 1'b1};
    vt[8]  = '{1'b0, 3'b010, 3'b010, 1'b1, 3'd2, 16'h0022, 1'b1};
    vt[9]  = '{1'b0, 3'b010, 3'b000, 1'b0, 3'd2, 16'h0022, 1'b1};
    vt[10] = '{1'b0, 3'b010, 3'b010, 1'b1, 3'd2, 16'h0022, 1'b1};
    vt[11] = '{1'b0, 3'b010, 3'b000, 1'b0, 3'd2, 16'h0022, 1'b1};
    vt[12] = '{1'b0, 3'b000, 3'b000, 1'b0, 3'd2, 16'h0022, 1'b1};
    // ptr=2 here: pairs of requesters keep rf_write high every cycle.
    vt[13] = '{1'b0, 3'b011, 3'b001, 1'b1, 3'd1, 16'h0011, 1'b1};
    vt[14] = '{1'b0, 3'b011, 3'b010, 1'b1, 3'd2, 16'h0022, 1'b1};
    vt[15] = '{1'b0, 3'b011, 3'b001, 1'b1, 3'd1, 16'h0011, 1'b1};
    vt[16] = '{1'b0, 3'b101, 3'b100, 1'b1, 3'd3, 16'h0033, 1'b1};
    vt[17] = '{1'b0, 3'b101, 3'b001, 1'b1, 3'd1, 16'h0011, 1'b1};
    vt[18] = '{1'b0, 3'b000, 3'b000, 1'b0, 3'd1, 16'h0011, 1'b1};
    // zero wins over a pending request; nothing granted on that edge.
    vt[19] = '{1'b1, 3'b010, 3'b000, 1'b0, 3'd1, 16'h0011, 1'b0};

    #2 clear_n = 1'b0;
    #10;
    check("reset_state", 3'b000, 1'b0, 3'd0, 16'h0000, 1'b0);
    clear_n = 1'b1;

    // Initial zero-fill sweep.
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("init_%0d", i), 3'b000, 1'b1, 3'(i), 16'h0000, 1'b0);
    end
    tick();
    check("ready_after_init", 3'b000, 1'b0, 3'd7, 16'h0000, 1'b1);

    // Table-driven RUN vectors.
    for (int v = 0; v < 20; v++) begin
      bus.zero = vt[v].zero;
      bus.req  = vt[v].req;
      tick();
      check($sformatf("vec_%0d", v), vt[v].exp_ack, vt[v].exp_wr, vt[v].exp_addr,
            vt[v].exp_data, vt[v].exp_ready);
    end

    // After zero: full sweep with req[1] still pending, then its grant.
    bus.zero = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("zero_init_%0d", i), 3'b000, 1'b1, 3'(i), 16'h0000, 1'b0);
    end
    tick();
    check("zero_then_grant1", 3'b010, 1'b1, 3'd2, 16'h0022, 1'b1);
    bus.req = 3'b000;
    tick();
    check("zero_then_idle", 3'b000, 1'b0, 3'd2, 16'h0022, 1'b1);

    // Reset in the middle of an INIT sweep (cnt = 5).
    bus.zero = 1'b1;
    tick();
    check("zero_edge2", 3'b000, 1'b0, 3'd2, 16'h0022, 1'b0);
    bus.zero = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("pre_abort_%0d", i), 3'b000, 1'b1, 3'(i), 16'h0000, 1'b0);
    end
    #1 clear_n = 1'b0;
    #1;
    check("abort_init_async", 3'b000, 1'b0, 3'd0, 16'h0000, 1'b0);
    tick();
    check("abort_init_held", 3'b000, 1'b0, 3'd0, 16'h0000, 1'b0);
    clear_n = 1'b1;

    // Restarted sweep; req[0] raised during INIT cycle 3 must wait.
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("restart_init_%0d", i), 3'b000, 1'b1, 3'(i), 16'h0000, 1'b0);
      if (i == 2) bus.req = 3'b001;
    end
    tick();
    check("held_req0_grant", 3'b001, 1'b1, 3'd1, 16'h0011, 1'b1);
    bus.req = 3'b000;
    tick();
    check("held_req0_idle", 3'b000, 1'b0, 3'd1, 16'h0011, 1'b1);

    // Reset right after a grant clears the ack pulse at once.
    bus.req = 3'b100;
    tick();
    check("grant2_before_abort", 3'b100, 1'b1, 3'd3, 16'h0033, 1'b1);
    #1 clear_n = 1'b0;
    #1;
    check("abort_grant_async", 3'b000, 1'b0, 3'd0, 16'h0000, 1'b0);
    bus.req = 3'b000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
